// File: rtl/cc_level_rowstreamer.sv
// -----------------------------------------------------------------------------
// cc_level_rowstreamer
//
// Programmable row-pattern source for the Frogger lane engine. A writable table
// of LEVELS x ROWS patterns (DATAWIDTH bits each) is held in flops. A Start
// request streams the rows of one level, in order, over a valid/ready link.
//
// Optional feature macro: CC_LEVEL_ROWSTREAMER_LOOP_EN
//   defined   : after the last row the stream wraps to row 0 of the same level
//               and keeps running until reset (Done pulses on every wrap).
//   undefined : after the last row the block returns to IDLE.
//
// Ports:
//   CC_LEVEL_ROWSTREAMER_CLOCK_50         system clock (rising edge)
//   CC_LEVEL_ROWSTREAMER_RESET_InLow      asynchronous active-low reset
//   CC_LEVEL_ROWSTREAMER_Start_In         start request (sampled in IDLE)
//   CC_LEVEL_ROWSTREAMER_Level_InBus      level to stream, sampled with Start
//   CC_LEVEL_ROWSTREAMER_Ready_In         consumer accepts the current row
//   CC_LEVEL_ROWSTREAMER_WrEn_In          table write strobe
//   CC_LEVEL_ROWSTREAMER_WrLevel_InBus    write level index
//   CC_LEVEL_ROWSTREAMER_WrRow_InBus      write row index (0-based)
//   CC_LEVEL_ROWSTREAMER_WrData_InBus     write data
//   CC_LEVEL_ROWSTREAMER_RowData_OutBus   current row pattern (registered)
//   CC_LEVEL_ROWSTREAMER_Valid_Out        RowData valid
//   CC_LEVEL_ROWSTREAMER_Progress_OutBus  1-based index of presented row, 0 idle
//   CC_LEVEL_ROWSTREAMER_Done_Out         1-cycle pulse after last row accepted
//   CC_LEVEL_ROWSTREAMER_Busy_Out         high while streaming
//   CC_LEVEL_ROWSTREAMER_Err_Out          1-cycle pulse on a rejected Start
// -----------------------------------------------------------------------------
module cc_level_rowstreamer #(
  parameter int DATAWIDTH      = 8,
  parameter int LEVELS         = 4,
  parameter int ROWS           = 13,
  parameter int LEVEL_WIDTH    = 3,
  parameter int PROGRESS_WIDTH = 5
) (
  input  logic                      CC_LEVEL_ROWSTREAMER_CLOCK_50,
  input  logic                      CC_LEVEL_ROWSTREAMER_RESET_InLow,
  input  logic                      CC_LEVEL_ROWSTREAMER_Start_In,
  input  logic [LEVEL_WIDTH-1:0]    CC_LEVEL_ROWSTREAMER_Level_InBus,
  input  logic                      CC_LEVEL_ROWSTREAMER_Ready_In,
  input  logic                      CC_LEVEL_ROWSTREAMER_WrEn_In,
  input  logic [LEVEL_WIDTH-1:0]    CC_LEVEL_ROWSTREAMER_WrLevel_InBus,
  input  logic [PROGRESS_WIDTH-1:0] CC_LEVEL_ROWSTREAMER_WrRow_InBus,
  input  logic [DATAWIDTH-1:0]      CC_LEVEL_ROWSTREAMER_WrData_InBus,
  output logic [DATAWIDTH-1:0]      CC_LEVEL_ROWSTREAMER_RowData_OutBus,
  output logic                      CC_LEVEL_ROWSTREAMER_Valid_Out,
  output logic [PROGRESS_WIDTH-1:0] CC_LEVEL_ROWSTREAMER_Progress_OutBus,
  output logic                      CC_LEVEL_ROWSTREAMER_Done_Out,
  output logic                      CC_LEVEL_ROWSTREAMER_Busy_Out,
  output logic                      CC_LEVEL_ROWSTREAMER_Err_Out
);

  localparam int ENTRIES = LEVELS * ROWS;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [PROGRESS_WIDTH-1:0] PROG_ZERO  = {PROGRESS_WIDTH{1'b0}};
  localparam logic [PROGRESS_WIDTH-1:0] PROG_ONE   = PROGRESS_WIDTH'(32'd1);
  localparam logic [PROGRESS_WIDTH-1:0] PROG_LAST  = PROGRESS_WIDTH'(ROWS);
  localparam logic [PROGRESS_WIDTH-1:0] ROW_FIRST  = {PROGRESS_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Level index is legal when it addresses a stored level.
  function automatic logic level_ok(input logic [LEVEL_WIDTH-1:0] lvl);
    return (32'(lvl) < 32'(LEVELS));
  endfunction

  // Row index is legal when it addresses a stored row.
  function automatic logic row_ok(input logic [PROGRESS_WIDTH-1:0] row);
    return (32'(row) < 32'(ROWS));
  endfunction

  // Flattened table address: level-major, row-minor.
  function automatic logic [IDX_W-1:0] entry_idx(input logic [LEVEL_WIDTH-1:0]    lvl,
                                                  input logic [PROGRESS_WIDTH-1:0] row);
    return IDX_W'(32'(lvl) * 32'(ROWS) + 32'(row));
  endfunction

  state_t                      state_q, state_d;
  logic [LEVEL_WIDTH-1:0]      level_q, level_d;
  logic [DATAWIDTH-1:0]        row_data_q, row_data_d;
  logic                        valid_q, valid_d;
  logic [PROGRESS_WIDTH-1:0]   progress_q, progress_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        err_q, err_d;
  logic [DATAWIDTH-1:0]        tbl_q [ENTRIES];
  logic [DATAWIDTH-1:0]        tbl_d [ENTRIES];

  logic                        wr_hit_s;
  logic [IDX_W-1:0]            wr_idx_s;

  assign wr_hit_s = CC_LEVEL_ROWSTREAMER_WrEn_In
                  & level_ok(CC_LEVEL_ROWSTREAMER_WrLevel_InBus)
                  & row_ok(CC_LEVEL_ROWSTREAMER_WrRow_InBus);
  assign wr_idx_s = entry_idx(CC_LEVEL_ROWSTREAMER_WrLevel_InBus,
                              CC_LEVEL_ROWSTREAMER_WrRow_InBus);

  // Table update: out-of-range writes are dropped, never aliased onto another entry.
  always_comb begin
    tbl_d = tbl_q;
    if (wr_hit_s) begin
      tbl_d[wr_idx_s] = CC_LEVEL_ROWSTREAMER_WrData_InBus;
    end else begin
      tbl_d = tbl_q;
    end
  end

  // Stream control: next state and next output values.
  // Rows are fetched from tbl_q (pre-write contents), so a same-edge write is
  // deliberately not forwarded into RowData.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    row_data_d = row_data_q;
    valid_d    = valid_q;
    progress_d = progress_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CC_LEVEL_ROWSTREAMER_Start_In) begin
          if (level_ok(CC_LEVEL_ROWSTREAMER_Level_InBus)) begin
            state_d    = ST_RUN;
            level_d    = CC_LEVEL_ROWSTREAMER_Level_InBus;
            row_data_d = tbl_q[entry_idx(CC_LEVEL_ROWSTREAMER_Level_InBus, ROW_FIRST)];
            valid_d    = 1'b1;
            progress_d = PROG_ONE;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (valid_q && CC_LEVEL_ROWSTREAMER_Ready_In) begin
          if (progress_q != PROG_LAST) begin
            // Progress is 1-based, so it is already the 0-based index of the next row.
            row_data_d = tbl_q[entry_idx(level_q, progress_q)];
            progress_d = progress_q + PROG_ONE;
          end else begin
            done_d = 1'b1;
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
            row_data_d = tbl_q[entry_idx(level_q, ROW_FIRST)];
            progress_d = PROG_ONE;
`else
            state_d    = ST_IDLE;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            progress_d = PROG_ZERO;
`endif
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        progress_d = PROG_ZERO;
      end
    endcase
  end

  // State, output and table registers.
  always_ff @(posedge CC_LEVEL_ROWSTREAMER_CLOCK_50 or negedge CC_LEVEL_ROWSTREAMER_RESET_InLow) begin
    if (!CC_LEVEL_ROWSTREAMER_RESET_InLow) begin
      state_q    <= ST_IDLE;
      level_q    <= {LEVEL_WIDTH{1'b0}};
      row_data_q <= {DATAWIDTH{1'b0}};
      valid_q    <= 1'b0;
      progress_q <= PROG_ZERO;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= {DATAWIDTH{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      row_data_q <= row_data_d;
      valid_q    <= valid_d;
      progress_q <= progress_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tbl_q      <= tbl_d;
    end
  end

  assign CC_LEVEL_ROWSTREAMER_RowData_OutBus  = row_data_q;
  assign CC_LEVEL_ROWSTREAMER_Valid_Out       = valid_q;
  assign CC_LEVEL_ROWSTREAMER_Progress_OutBus = progress_q;
  assign CC_LEVEL_ROWSTREAMER_Done_Out        = done_q;
  assign CC_LEVEL_ROWSTREAMER_Busy_Out        = busy_q;
  assign CC_LEVEL_ROWSTREAMER_Err_Out         = err_q;

endmodule

// File: tb/tb_cc_level_rowstreamer.sv
// -----------------------------------------------------------------------------
// Testbench for cc_level_rowstreamer (LEVELS=4, ROWS=13). A behavioural model
// (table array + stream position) predicts every output after each clock edge.
// Honours CC_LEVEL_ROWSTREAMER_LOOP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_cc_level_rowstreamer;

  localparam int DW = 8;
  localparam int LV = 4;
  localparam int RW = 13;
  localparam int LW = 3;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [LW-1:0] lvl_in = '0;
  logic          ready_in = 1'b0;
  logic          wr_en = 1'b0;
  logic [LW-1:0] wr_lvl = '0;
  logic [PW-1:0] wr_row = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] row_data;
  logic          valid;
  logic [PW-1:0] progress;
  logic          done;
  logic          busy;
  logic          err;

  cc_level_rowstreamer #(
    .DATAWIDTH(DW), .LEVELS(LV), .ROWS(RW), .LEVEL_WIDTH(LW), .PROGRESS_WIDTH(PW)
  ) dut (
    .CC_LEVEL_ROWSTREAMER_CLOCK_50        (clk),
    .CC_LEVEL_ROWSTREAMER_RESET_InLow     (rst_n),
    .CC_LEVEL_ROWSTREAMER_Start_In        (start_in),
    .CC_LEVEL_ROWSTREAMER_Level_InBus     (lvl_in),
    .CC_LEVEL_ROWSTREAMER_Ready_In        (ready_in),
    .CC_LEVEL_ROWSTREAMER_WrEn_In         (wr_en),
    .CC_LEVEL_ROWSTREAMER_WrLevel_InBus   (wr_lvl),
    .CC_LEVEL_ROWSTREAMER_WrRow_InBus     (wr_row),
    .CC_LEVEL_ROWSTREAMER_WrData_InBus    (wr_data),
    .CC_LEVEL_ROWSTREAMER_RowData_OutBus  (row_data),
    .CC_LEVEL_ROWSTREAMER_Valid_Out       (valid),
    .CC_LEVEL_ROWSTREAMER_Progress_OutBus (progress),
    .CC_LEVEL_ROWSTREAMER_Done_Out        (done),
    .CC_LEVEL_ROWSTREAMER_Busy_Out        (busy),
    .CC_LEVEL_ROWSTREAMER_Err_Out         (err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mtab [LV][RW];
  logic [DW-1:0] m_data;
  logic          m_valid, m_done, m_busy, m_err;
  int            m_prog, m_level;

  int checks = 0;
  int passed = 0;

  function automatic logic [DW+PW+3:0] obs();
    return {row_data, valid, progress, done, busy, err};
  endfunction

  function automatic logic [DW+PW+3:0] expv();
    return {m_data, m_valid, PW'(m_prog), m_done, m_busy, m_err};
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LV; l++)
      for (int r = 0; r < RW; r++) mtab[l][r] = '0;
    m_data = '0; m_valid = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    m_prog = 0; m_level = 0;
  endtask

  task automatic idle_inputs();
    start_in = 1'b0; lvl_in = '0; ready_in = 1'b0;
    wr_en = 1'b0; wr_lvl = '0; wr_row = '0; wr_data = '0;
  endtask

  // Advance one clock: predict from the rules using the inputs now applied,
  // then let the edge happen and settle.
  task automatic tick();
    int sl, wl, wr;
    sl = int'(lvl_in); wl = int'(wr_lvl); wr = int'(wr_row);
    m_done = 1'b0; m_err = 1'b0;
    if (!m_busy) begin
      if (start_in) begin
        if (sl < LV) begin
          m_busy = 1'b1; m_valid = 1'b1; m_level = sl; m_prog = 1; m_data = mtab[sl][0];
        end else m_err = 1'b1;
      end
    end else if (ready_in) begin
      if (m_prog < RW) begin
        m_data = mtab[m_level][m_prog];
        m_prog++;
      end else begin
        m_done = 1'b1;
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
        m_data = mtab[m_level][0];
        m_prog = 1;
`else
        m_busy = 1'b0; m_valid = 1'b0; m_prog = 0;
`endif
      end
    end
    if (wr_en && wl < LV && wr < RW) mtab[wl][wr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Accept rows until the level completes (or wraps); bounded.
  task automatic run_out(input string name);
    int cyc;
    cyc = 0;
    idle_inputs();
    ready_in = 1'b1;
    while (m_busy && !m_done && cyc < 100) begin
      tick();
      cyc++;
    end
    if (m_busy && !m_done) begin
      checks++;
      $display("FAIL %s_timeout: model never completed stream", name);
    end
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
    apply_reset();
`endif
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (obs() !== '0) $display("FAIL reset_state: got %h want 0", obs());
    else passed++;
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== expv()) $display("FAIL reset_idle: got %h want %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_empty_table();
    start_in = 1'b1; lvl_in = 3'd1; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 1; i <= RW; i++) begin
      checks++;
      if (obs() !== expv() || progress !== PW'(i) || row_data !== 8'h00 || valid !== 1'b1 || busy !== 1'b1)
        $display("FAIL empty_row%0d: got %h want %h", i, obs(), expv());
      else passed++;
      tick();
    end
    checks++;
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
    if (done !== 1'b1 || valid !== 1'b1 || progress !== 5'd1 || row_data !== 8'h00 || busy !== 1'b1)
`else
    if (done !== 1'b1 || valid !== 1'b0 || progress !== 5'd0 || busy !== 1'b0)
`endif
      $display("FAIL empty_end: got %h want %h", obs(), expv());
    else passed++;
    ready_in = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || obs() !== expv()) $display("FAIL empty_done_width: got %h want %h", obs(), expv());
    else passed++;
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
    apply_reset();
`endif
  endtask

  task automatic test_programmed_rows();
    logic [DW-1:0] pat [3];
    pat[0] = 8'hD0; pat[1] = 8'h90; pat[2] = 8'h60;
    idle_inputs();
    for (int r = 0; r < RW; r++) begin
      wr_en = 1'b1; wr_lvl = 3'd2; wr_row = PW'(r);
      wr_data = (r < 3) ? pat[r] : DW'($urandom);
      tick();
    end
    // Out-of-range writes must not land anywhere
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_data = 8'hFF;
      if (k < 4) begin wr_lvl = LW'($urandom_range(4, 7)); wr_row = PW'($urandom_range(0, 12)); end
      else begin wr_lvl = LW'($urandom_range(0, 3)); wr_row = PW'($urandom_range(13, 31)); end
      tick();
    end
    idle_inputs();
    start_in = 1'b1; lvl_in = 3'd2; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== expv() || row_data !== pat[i] || progress !== PW'(i + 1))
        $display("FAIL prog_row%0d: got %h want %h", i, obs(), expv());
      else passed++;
      tick();
    end
    run_out("prog");
    // Level 1 should still be all-zero after the dropped writes
    start_in = 1'b1; lvl_in = 3'd1; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < RW; i++) begin
      checks++;
      if (obs() !== expv()) $display("FAIL dropped_wr_row%0d: got %h want %h", i, obs(), expv());
      else passed++;
      tick();
    end
    run_out("dropped");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    int cyc;
    start_in = 1'b1; lvl_in = 3'd2; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc = 0;
    while (m_prog != 4 && cyc < 20) begin tick(); cyc++; end
    ready_in = 1'b0;
    held = row_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (row_data !== held || progress !== 5'd4 || valid !== 1'b1 || obs() !== expv())
        $display("FAIL bp_hold%0d: got %h want %h", i, obs(), expv());
      else passed++;
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if (progress !== 5'd5 || obs() !== expv()) $display("FAIL bp_resume: got %h want %h", obs(), expv());
    else passed++;
    run_out("bp");
  endtask

  task automatic test_rejected_start();
    logic [LW-1:0] bad [3];
    bad[0] = 3'd5; bad[1] = 3'd4; bad[2] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      start_in = 1'b1; lvl_in = bad[k];
      tick();
      start_in = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || obs() !== expv())
        $display("FAIL reject_l%0d: got %h want %h", bad[k], obs(), expv());
      else passed++;
      tick();
      checks++;
      if (err !== 1'b0 || obs() !== expv()) $display("FAIL reject_width_l%0d: got %h want %h", bad[k], obs(), expv());
      else passed++;
    end
  endtask

  task automatic test_ignored_start();
    start_in = 1'b1; lvl_in = 3'd2; ready_in = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      start_in = 1'b1; lvl_in = (i < 3) ? 3'd3 : 3'd6;
      tick();
      checks++;
      if (err !== 1'b0 || row_data !== mtab[2][m_prog - 1] || obs() !== expv())
        $display("FAIL ignored_start%0d: got %h want %h", i, obs(), expv());
      else passed++;
    end
    run_out("ignored");
  endtask

  task automatic test_collision();
    logic [DW-1:0] old;
    idle_inputs();
    for (int r = 0; r < RW; r++) begin
      wr_en = 1'b1; wr_lvl = 3'd0; wr_row = PW'(r); wr_data = DW'(8'h10 + r);
      tick();
    end
    // Rewrite the very entry being fetched on each load edge
    start_in = 1'b1; lvl_in = 3'd0; ready_in = 1'b1;
    wr_en = 1'b1; wr_lvl = 3'd0; wr_row = 5'd0; wr_data = 8'hEE;
    old = mtab[0][0];
    tick();
    start_in = 1'b0;
    for (int i = 1; i < RW; i++) begin
      checks++;
      if (row_data !== old || obs() !== expv()) $display("FAIL collide_row%0d: got %h want %h", i - 1, obs(), expv());
      else passed++;
      old = mtab[0][i];
      wr_row = PW'(i); wr_data = ~old;
      tick();
    end
    wr_en = 1'b0;
    run_out("collide");
    // The new contents are seen by later loads
    start_in = 1'b1; lvl_in = 3'd0; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    checks++;
    if (row_data !== 8'hEE || obs() !== expv()) $display("FAIL collide_visible: got %h want %h", obs(), expv());
    else passed++;
    run_out("collide2");
  endtask

  task automatic test_random_streams();
    int cyc;
    for (int it = 0; it < 8; it++) begin
      idle_inputs();
      start_in = 1'b1; lvl_in = LW'($urandom_range(0, 3)); ready_in = 1'($urandom_range(0, 1));
      tick();
      cyc = 0;
      while (!m_done && cyc < 200) begin
        start_in = ($urandom_range(0, 3) == 0);
        lvl_in   = LW'($urandom_range(0, 7));
        ready_in = ($urandom_range(0, 2) != 0);
        wr_en    = ($urandom_range(0, 1) == 1);
        wr_lvl   = LW'($urandom_range(0, 7));
        wr_row   = PW'($urandom_range(0, 15));
        wr_data  = DW'($urandom);
        tick();
        cyc++;
        checks++;
        if (obs() !== expv()) $display("FAIL rand_it%0d_c%0d: got %h want %h", it, cyc, obs(), expv());
        else passed++;
      end
      if (!m_done) begin
        checks++;
        $display("FAIL rand_timeout_it%0d: no Done within budget", it);
      end
      idle_inputs();
`ifdef CC_LEVEL_ROWSTREAMER_LOOP_EN
      apply_reset();
`endif
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    idle_inputs();
    wr_en = 1'b1; wr_lvl = 3'd2; wr_row = 5'd0; wr_data = 8'hD0;
    tick();
    idle_inputs();
    start_in = 1'b1; lvl_in = 3'd2; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc = 0;
    while (m_prog != 7 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (progress !== 5'd7 || obs() !== expv()) $display("FAIL rstmid_pre: got %h want %h", obs(), expv());
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) $display("FAIL rstmid_immediate: got %h want 0", obs());
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || obs() !== expv()) $display("FAIL rstmid_nodone%0d: got %h want %h", i, obs(), expv());
      else passed++;
    end
    start_in = 1'b1; lvl_in = 3'd2; ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    checks++;
    if (row_data !== 8'h00 || progress !== 5'd1 || valid !== 1'b1 || obs() !== expv())
      $display("FAIL rstmid_cleared: got %h want %h", obs(), expv());
    else passed++;
    run_out("rstmid");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_empty_table();
    test_programmed_rows();
    test_backpressure();
    test_rejected_start();
    test_ignored_start();
    test_collision();
    test_random_streams();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cc_level_rowstreamer.md
# cc_level_rowstreamer

Programmable, handshaked row-pattern source for the Frogger lane engine, and the successor to the combinational level lookup. It holds a writable table of `LEVELS × ROWS` row patterns, each `DATAWIDTH` bits wide. On a start request it streams one level's rows in order to the downstream lane/display logic over a valid/ready interface. Per-row progress, completion and error status go to the game controller.

## Interface
Parameters:
- `DATAWIDTH`, 8: bits per row pattern.
- `LEVELS`, 4: number of levels stored (≥1).
- `ROWS`, 13: rows per level (≥2).
- `LEVEL_WIDTH`, 3: width of level selects; must hold `LEVELS-1`.
- `PROGRESS_WIDTH`, 5: width of progress and row-address buses; must hold `ROWS`.

Ports:
- `CC_LEVEL_ROWSTREAMER_CLOCK_50`  in  1  system clock; all state is on its rising edge.
- `CC_LEVEL_ROWSTREAMER_RESET_InLow`  in  1  asynchronous, active-low reset.
- `CC_LEVEL_ROWSTREAMER_Start_In`  in  1  start request, sampled only in IDLE.
- `CC_LEVEL_ROWSTREAMER_Level_InBus`  in  `LEVEL_WIDTH`  level to stream, sampled with Start.
- `CC_LEVEL_ROWSTREAMER_Ready_In`  in  1  consumer accepts the current row.
- `CC_LEVEL_ROWSTREAMER_WrEn_In`  in  1  table write strobe.
- `CC_LEVEL_ROWSTREAMER_WrLevel_InBus`  in  `LEVEL_WIDTH`  write level index.
- `CC_LEVEL_ROWSTREAMER_WrRow_InBus`  in  `PROGRESS_WIDTH`  write row index (0-based).
- `CC_LEVEL_ROWSTREAMER_WrData_InBus`  in  `DATAWIDTH`  write data.
- `CC_LEVEL_ROWSTREAMER_RowData_OutBus`  out  `DATAWIDTH`  current row pattern (registered).
- `CC_LEVEL_ROWSTREAMER_Valid_Out`  out  1  RowData is valid.
- `CC_LEVEL_ROWSTREAMER_Progress_OutBus`  out  `PROGRESS_WIDTH`  1-based index of the presented row; 0 when idle.
- `CC_LEVEL_ROWSTREAMER_Done_Out`  out  1  one-cycle pulse after the last row is accepted.
- `CC_LEVEL_ROWSTREAMER_Busy_Out`  out  1  high while in RUN.
- `CC_LEVEL_ROWSTREAMER_Err_Out`  out  1  one-cycle pulse when a Start is rejected.

## Operation
- **Table:** flop array of `LEVELS × ROWS` entries, cleared to 0 by reset.
  - A write occurs when `WrEn` is high and `WrLevel < LEVELS` and `WrRow < ROWS`. Any other write is silently dropped.
  - Writes are accepted in any state.
- **State machine:** two states, IDLE and RUN.
- **IDLE → RUN:** on `Start` with `Level < LEVELS`. The block latches the level, loads row 0 into RowData, and sets Progress=1 and Valid=1.
- **IDLE, rejected start:** on `Start` with `Level ≥ LEVELS`, Err pulses for 1 cycle and the state stays IDLE.
- **RUN transfer:** occurs when `Valid && Ready`.
  - If Progress < `ROWS`: load the next row and increment Progress.
  - If Progress = `ROWS` (last row): end-of-level handling; see Configuration.
- **RUN hold:** while `Valid && !Ready`, RowData, Progress and Valid hold unchanged.
- **Ignored inputs in RUN:** `Start` in RUN is ignored; no Err pulse, no restart.
- **Read/write collision:** rows are read from the table at the load edge. A write to the same entry on the same edge is not forwarded; the old content is loaded. A row already in RowData is never altered by later writes.
- **Level latching:** the streamed level is latched at Start. Changes on `Level_InBus` during RUN have no effect.

## Timing
- **Reset:** asserting `RESET_InLow` low immediately forces:
  - state IDLE;
  - RowData=0, Valid=0, Progress=0, Done=0, Busy=0, Err=0;
  - all table entries to 0.
  - Reset mid-stream aborts the stream with no Done pulse.
- **Start latency:** a Start accepted at edge N gives Valid=1, Busy=1, row 0 and Progress=1 after edge N.
- **Throughput:** with Ready held high, one row per cycle. Level L takes `ROWS` cycles from first Valid to last transfer.
- **Done:** asserted for exactly 1 cycle, in the cycle after the last transfer edge.
- **Err:** asserted for exactly 1 cycle, in the cycle after the rejected Start.
- **Write latency:** a write at edge N is visible to any load at edge N+1 or later.

## Configuration
- **Macro `CC_LEVEL_ROWSTREAMER_LOOP_EN`, defined:** the last transfer wraps to row 0 of the same level. RowData=row 0, Progress=1, Valid stays 1, and Busy stays 1. Done still pulses on every wrap. The stream runs until reset.
- **Macro not defined:** the last transfer goes to IDLE. Valid=0, Busy=0, Progress=0, and RowData holds the last row. Done pulses for 1 cycle.

## Test plan
Bench settings: `LEVELS`=4, `ROWS`=13.
- **Empty table:** release reset, then Start with Level=1 and Ready=1 → Valid for 13 cycles, RowData=8'h00 throughout, Progress 1..13, then Done for 1 cycle.
- **Programmed rows:** write level 2 rows 0/1/2 = 8'hD0/8'h90/8'h60, then Start with Level=2 and Ready=1 → RowData D0, 90, 60 on consecutive cycles with Progress 1, 2, 3.
- **Backpressure:** drop Ready for 5 cycles at Progress=4 → RowData, Progress and Valid stable for those 5 cycles; Progress=5 one cycle after Ready returns.
- **End of level:** complete all 13 transfers.
  - Without the macro → Done=1 for 1 cycle, Valid=0, Busy=0, Progress=0.
  - With the macro → Done=1 for 1 cycle, Valid=1, Progress=1, RowData equals row 0.
- **Rejected and ignored starts:** Start with Level=5 → Err=1 for 1 cycle, Busy stays 0. Start with Level=3 during RUN → no change in stream or level.
- **Reset mid-stream:** assert reset at Progress=7 → all outputs 0 immediately, no Done pulse. Restart the previously written level 2 → row 0 reads 8'h00.
